// File: rtl/div_32bit_seq.sv
// ---------------------------------------------------------------------------
// div_32bit_seq
// Multi-cycle signed integer divider. It produces one quotient bit per cycle
// using non-restoring division on operand magnitudes, then fixes up the
// remainder and applies the result signs (truncation toward zero).
// The result is packed as {remainder, quotient}, so HI/LO load the same way
// they do after a multiply.
//
// Optional feature macro: DIV_UNSIGNED_EN
//   When defined, the input is_unsigned is added. It is sampled with start.
//   When it is 1, the operands are treated as unsigned: no magnitude
//   conversion is done and no result negation is applied.
//
// Ports
//   clock        rising-edge clock
//   clear        asynchronous active-high reset
//   start        divide request, accepted only while idle
//   Ra, Rb       dividend / divisor (two's complement), captured on start
//   is_unsigned  (DIV_UNSIGNED_EN only) unsigned-divide select
//   busy         high from the cycle after start is accepted until done
//   done         one-cycle pulse; Rz and div_by_zero are valid from here
//   div_by_zero  high with done when the divisor was zero
//   Rz           {remainder, quotient}; holds the last result
// ---------------------------------------------------------------------------
module div_32bit_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               start,
    input  logic [WIDTH-1:0]   Ra,
    input  logic [WIDTH-1:0]   Rb,
`ifdef DIV_UNSIGNED_EN
    input  logic               is_unsigned,
`endif
    output logic               busy,
    output logic               done,
    output logic               div_by_zero,
    output logic [2*WIDTH-1:0] Rz
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   p_reg;
    logic [WIDTH-1:0] q_reg;
    logic             sign_q;
    logic             sign_r;
    logic             zero_div;
    logic [CW-1:0]    count;

    logic             op_unsigned;
    logic             ra_neg;
    logic             rb_neg;
    logic [WIDTH-1:0] ra_mag;
    logic [WIDTH-1:0] rb_mag;
    logic [WIDTH:0]   b_ext;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   p_next;
    logic [WIDTH-1:0] rem_fixed;
    logic [WIDTH-1:0] rem_out;
    logic [WIDTH-1:0] quo_out;

`ifdef DIV_UNSIGNED_EN
    assign op_unsigned = is_unsigned;
`else
    assign op_unsigned = 1'b0;
`endif

    // Operand magnitudes. The most negative value negates to itself, which
    // read as an unsigned W-bit number is exactly 2^(W-1).
    always_comb begin
        ra_neg = ~op_unsigned & Ra[WIDTH-1];
        rb_neg = ~op_unsigned & Rb[WIDTH-1];
        ra_mag = ra_neg ? (~Ra) + ONE_W : Ra;
        rb_mag = rb_neg ? (~Rb) + ONE_W : Rb;
    end

    // One non-restoring step: shift {P,Q} left, then subtract the divisor
    // when P was non-negative or add it back when P was negative.
    // W+1 bits is enough because |P| stays below the divisor.
    always_comb begin
        b_ext   = {1'b0, b_mag};
        shifted = {p_reg[WIDTH-1:0], q_reg[WIDTH-1]};
        p_next  = p_reg[WIDTH] ? shifted + b_ext : shifted - b_ext;
    end

    // Final correction: a negative partial remainder gets one divisor added
    // back. After that the signs are applied: the quotient takes the XOR of
    // the operand signs and the remainder takes the dividend's sign.
    always_comb begin
        rem_fixed = p_reg[WIDTH] ? p_reg[WIDTH-1:0] + b_mag : p_reg[WIDTH-1:0];
        rem_out   = sign_r ? (~rem_fixed) + ONE_W : rem_fixed;
        quo_out   = sign_q ? (~q_reg) + ONE_W : q_reg;
    end

    // Control and datapath sequencing. Rz and div_by_zero change only when
    // leaving DONE, so they keep the previous result during an operation.
    // A zero divisor skips the iterations and goes straight to DONE.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state       <= IDLE;
            a_raw       <= '0;
            b_mag       <= '0;
            p_reg       <= '0;
            q_reg       <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            zero_div    <= 1'b0;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            Rz          <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_raw  <= Ra;
                        b_mag  <= rb_mag;
                        q_reg  <= ra_mag;
                        p_reg  <= '0;
                        count  <= '0;
                        sign_q <= ra_neg ^ rb_neg;
                        sign_r <= ra_neg;
                        busy   <= 1'b1;
                        if (Rb == '0) begin
                            zero_div <= 1'b1;
                            state    <= DONE;
                        end else begin
                            zero_div <= 1'b0;
                            state    <= CALC;
                        end
                    end
                end
                CALC: begin
                    p_reg <= p_next;
                    q_reg <= {q_reg[WIDTH-2:0], ~p_next[WIDTH]};
                    count <= count + 1'b1;
                    if (count == LAST_CNT) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    p_reg <= {1'b0, rem_out};
                    q_reg <= quo_out;
                    state <= DONE;
                end
                DONE: begin
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    div_by_zero <= zero_div;
                    if (zero_div) begin
                        Rz <= {a_raw, {WIDTH{1'b1}}};
                    end else begin
                        Rz <= {p_reg[WIDTH-1:0], q_reg};
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_32bit_seq.sv
// ---------------------------------------------------------------------------
// tb_div_32bit_seq
// Self-checking bench for div_32bit_seq. Directed and $urandom operands are
// compared against an arithmetic reference model built on longint
// division. The bench also checks done latency, busy, result hold,
// ignored starts and an asynchronous clear in the middle of a divide.
// Define DIV_UNSIGNED_EN to also exercise the unsigned mode.
// ---------------------------------------------------------------------------
module tb_div_32bit_seq;

    logic        clock;
    logic        clear;
    logic        start;
    logic [31:0] Ra;
    logic [31:0] Rb;
`ifdef DIV_UNSIGNED_EN
    logic        is_unsigned;
`endif
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [63:0] Rz;

    int checks   = 0;
    int failures = 0;

    div_32bit_seq #(.WIDTH(32)) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .Ra          (Ra),
        .Rb          (Rb),
`ifdef DIV_UNSIGNED_EN
        .is_unsigned (is_unsigned),
`endif
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .Rz          (Rz)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Record one comparison and report it when it does not match.
    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: plain arithmetic on the operands, with wide signed
    // integers so that the overflow case wraps naturally.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic uns,
                         output logic [63:0] rz, output logic dz, output int lat);
        longint sa, sb, sq, sr;
        logic [31:0] uq, ur;
        if (b == 32'd0) begin
            rz  = {a, 32'hFFFF_FFFF};
            dz  = 1'b1;
            lat = 1;
        end else if (uns) begin
            uq  = a / b;
            ur  = a % b;
            rz  = {ur, uq};
            dz  = 1'b0;
            lat = 34;
        end else begin
            sa  = longint'($signed(a));
            sb  = longint'($signed(b));
            sq  = sa / sb;
            sr  = sa % sb;
            rz  = {sr[31:0], sq[31:0]};
            dz  = 1'b0;
            lat = 34;
        end
    endtask

    // Run one divide. The bench starts it, scrambles the operand inputs,
    // optionally pulses start again at cycle mid_start, and waits for done
    // within a bounded number of cycles. It then checks the latency, the
    // result, busy, and that done lasts only one cycle.
    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b, input logic uns,
                                  input string tag, input int mid_start);
        logic [63:0] exp_rz;
        logic [63:0] rz_before;
        logic        exp_dz;
        int          exp_lat;
        int          edges;
        logic        got;
        logic        busy_ok;
        logic        hold_ok;
        logic        extra_done;
        model(a, b, uns, exp_rz, exp_dz, exp_lat);
        @(negedge clock);
        Ra    = a;
        Rb    = b;
`ifdef DIV_UNSIGNED_EN
        is_unsigned = uns;
`endif
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start     = 1'b0;
        Ra        = $urandom;
        Rb        = $urandom;
        rz_before = Rz;
        busy_ok   = busy;
        hold_ok   = 1'b1;
        edges     = 0;
        got       = 1'b0;
        while (!got && edges < 100) begin
            @(posedge clock);
            edges++;
            @(negedge clock);
            start = (edges == mid_start);
            if (done) begin
                got = 1'b1;
            end else begin
                if (busy !== 1'b1) busy_ok = 1'b0;
                if (Rz !== rz_before) hold_ok = 1'b0;
            end
        end
        start = 1'b0;
        check_output({tag, "_latency"}, 64'(edges), 64'(exp_lat));
        check_output({tag, "_rz"}, Rz, exp_rz);
        check_output({tag, "_dz"}, 64'(div_by_zero), 64'(exp_dz));
        check_output({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check_output({tag, "_busy_window"}, 64'(busy_ok), 64'd1);
        check_output({tag, "_rz_hold"}, 64'(hold_ok), 64'd1);
        @(negedge clock);
        check_output({tag, "_done_pulse"}, 64'(done), 64'd0);
        if (mid_start >= 0) begin
            extra_done = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clock);
                if (done || busy) extra_done = 1'b1;
            end
            check_output({tag, "_no_queued_op"}, 64'(extra_done), 64'd0);
        end
    endtask

    initial begin
        logic [31:0] a, b;
        logic        seen_done;
        start = 1'b0;
        Ra    = '0;
        Rb    = '0;
`ifdef DIV_UNSIGNED_EN
        is_unsigned = 1'b0;
`endif
        clear = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_output("reset_busy", 64'(busy), 64'd0);
        check_output("reset_done", 64'(done), 64'd0);
        check_output("reset_dz", 64'(div_by_zero), 64'd0);
        check_output("reset_rz", Rz, 64'd0);
        clear = 1'b0;

        // Directed cases
        apply_stimulus(32'd100, 32'd7, 1'b0, "pos_pos", -1);
        apply_stimulus(-32'sd100, 32'd7, 1'b0, "neg_pos", -1);
        apply_stimulus(32'd100, -32'sd7, 1'b0, "pos_neg", -1);
        apply_stimulus(32'd5, 32'd0, 1'b0, "div_zero", -1);
        apply_stimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "overflow", -1);
        apply_stimulus(-32'sd7, -32'sd7, 1'b0, "neg_neg_eq", -1);
        apply_stimulus(32'h8000_0000, 32'd3, 1'b0, "min_by_3", -1);
        apply_stimulus(32'd3, 32'd10, 1'b0, "small_by_big", -1);
        apply_stimulus(32'h7FFF_FFFF, 32'd1, 1'b0, "max_by_1", -1);
        apply_stimulus(32'd100, 32'd7, 1'b0, "ignored_start", 5);

        // Clear in the middle of a divide aborts it with no done pulse.
        @(negedge clock);
        Ra    = 32'd100;
        Rb    = 32'd7;
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (10) @(posedge clock);
        @(negedge clock);
        clear = 1'b1;
        #1;
        check_output("clear_busy", 64'(busy), 64'd0);
        check_output("clear_done", 64'(done), 64'd0);
        check_output("clear_dz", 64'(div_by_zero), 64'd0);
        check_output("clear_rz", Rz, 64'd0);
        repeat (2) @(negedge clock);
        clear = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done || busy) seen_done = 1'b1;
        end
        check_output("clear_no_done", 64'(seen_done), 64'd0);
        apply_stimulus(32'd1000, 32'd33, 1'b0, "after_clear", -1);

        // Randomized signed operands
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = $urandom;
                1: b = 32'($urandom_range(1, 20));
                2: b = -32'($urandom_range(1, 20));
                3: begin
                    b = $urandom;
                    a = 32'($urandom_range(0, 50));
                end
                default: b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
            endcase
            apply_stimulus(a, b, 1'b0, $sformatf("rand%0d", i), -1);
        end

`ifdef DIV_UNSIGNED_EN
        apply_stimulus(32'hFFFF_FFFF, 32'd2, 1'b1, "uns_max_by_2", -1);
        apply_stimulus(32'hFFFF_FFFF, 32'd0, 1'b1, "uns_div_zero", -1);
        for (int i = 0; i < 10; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(1, 100));
            apply_stimulus(a, b, 1'b1, $sformatf("urand%0d", i), -1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
